// File: rtl/perf_sampler_pkg.sv
// Shared widths, register map and FSM encoding for the periodic counter sampler.
package perf_sampler_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned AddrW = 3;
  localparam int unsigned SelW  = 5;

  localparam logic [AddrW-1:0] ADDR_CTRL   = 3'd0;
  localparam logic [AddrW-1:0] ADDR_PERIOD = 3'd1;
  localparam logic [AddrW-1:0] ADDR_THRESH = 3'd2;
  localparam logic [AddrW-1:0] ADDR_STATUS = 3'd3;
  localparam logic [AddrW-1:0] ADDR_DATA   = 3'd4;

  // CTRL register payload: EN at bit 0, SEL at bits [8:4]
  typedef struct packed {
    logic [SelW-1:0] sel;
    logic            en;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/perf_sampler_fifo.sv
// Small first-word-visible FIFO holding sampled deltas; caller guarantees no push when full without pop.
module perf_sampler_fifo #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DataWidth-1:0]         data_i,
  output logic [DataWidth-1:0]         head_o,
  output logic [$clog2(Depth):0]       usage_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wptr_q;
  logic [PtrW-1:0]      rptr_q;
  logic [CntW-1:0]      cnt_q;

  // Storage array, no reset needed: contents are only observed while counted valid
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  // Read/write pointers and fill level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PtrW'(1);
      if (pop_i)  rptr_q <= rptr_q + PtrW'(1);
      if (push_i && !pop_i)      cnt_q <= cnt_q + CntW'(1);
      else if (!push_i && pop_i) cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign usage_o = cnt_q;

endmodule

// File: rtl/perf_sampler.sv
// Periodic sampler: snapshots one perf counter per period, queues deltas, flags deltas over threshold.
module perf_sampler
  import perf_sampler_pkg::*;
#(
  parameter int unsigned NrCounters = 32,
  parameter int unsigned FifoDepth  = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            debug_mode_i,
  input  logic [NrCounters-1:0][XLEN-1:0] perf_counter_i,
  input  logic [AddrW-1:0]                addr_i,
  input  logic                            we_i,
  input  logic                            re_i,
  input  logic [XLEN-1:0]                 data_i,
  output logic [XLEN-1:0]                 data_o,
  output logic                            irq_o
);

  localparam int unsigned CntW = $clog2(FifoDepth) + 1;

  state_e          state_q, state_d;
  ctrl_t           ctrl_q;
  logic [XLEN-1:0] period_q, thresh_q;
  logic [XLEN-1:0] base_q, base_d;
  logic [XLEN-1:0] timer_q, timer_d;
  logic            ovf_q, irq_q;

  logic            wr_ctrl_c, wr_period_c, wr_thresh_c, wr_status_c;
  logic [XLEN-1:0] cnt_sel_c, delta_c, fifo_head;
  logic [CntW-1:0] fifo_usage;
  logic            sample_c, push_c, pop_c, full_c, empty_c;
  logic            ovf_set_c, irq_set_c;

  assign wr_ctrl_c   = we_i && (addr_i == ADDR_CTRL);
  assign wr_period_c = we_i && (addr_i == ADDR_PERIOD);
  assign wr_thresh_c = we_i && (addr_i == ADDR_THRESH);
  assign wr_status_c = we_i && (addr_i == ADDR_STATUS);

  // Selected counter; out-of-range selectors read as zero
  always_comb begin
    cnt_sel_c = '0;
    for (int unsigned i = 0; i < NrCounters; i++) begin
      if (ctrl_q.sel == SelW'(i)) cnt_sel_c = perf_counter_i[i];
    end
  end

  assign delta_c = cnt_sel_c - base_q;

  // Next-state, period timer and BASE capture
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    base_d   = base_q;
    sample_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (wr_ctrl_c && data_i[0]) state_d = ST_ARM;
      end
      ST_ARM: begin
        base_d  = cnt_sel_c;
        timer_d = '0;
        state_d = ST_RUN;
        if (wr_ctrl_c) state_d = data_i[0] ? ST_ARM : ST_IDLE;
      end
      ST_RUN: begin
        if (wr_ctrl_c) begin
          // Any CTRL write while running either stops or re-arms on the (new) selector
          state_d = data_i[0] ? ST_ARM : ST_IDLE;
          timer_d = '0;
        end else if (wr_period_c) begin
          timer_d = '0;
        end else if (!debug_mode_i && (period_q != '0)) begin
          if (timer_q == period_q - XLEN'(1)) begin
            sample_c = 1'b1;
            base_d   = cnt_sel_c;
            timer_d  = '0;
          end else begin
            timer_d = timer_q + XLEN'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign full_c    = (fifo_usage == CntW'(FifoDepth));
  assign empty_c   = (fifo_usage == '0);
  assign pop_c     = re_i && (addr_i == ADDR_DATA) && !empty_c;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push_c    = sample_c && (!full_c || pop_c);
  assign ovf_set_c = sample_c && full_c && !pop_c;
  assign irq_set_c = sample_c && (thresh_q != '0) && (delta_c >= thresh_q);

  // FSM state, timer and BASE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      base_q  <= base_d;
    end
  end

  // Software registers; set events win over W1C on the sticky bits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q   <= '0;
      period_q <= '0;
      thresh_q <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl_c)   ctrl_q   <= '{sel: data_i[8:4], en: data_i[0]};
      if (wr_period_c) period_q <= data_i;
      if (wr_thresh_c) thresh_q <= data_i;
      ovf_q <= ovf_set_c || (ovf_q && !(wr_status_c && data_i[8]));
      irq_q <= irq_set_c || (irq_q && !(wr_status_c && data_i[9]));
    end
  end

  perf_sampler_fifo #(
    .DataWidth (XLEN),
    .Depth     (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .data_i  (delta_c),
    .head_o  (fifo_head),
    .usage_o (fifo_usage)
  );

  // Combinational register read mux
  always_comb begin
    data_o = '0;
    unique case (addr_i)
      ADDR_CTRL: begin
        data_o[0]   = ctrl_q.en;
        data_o[8:4] = ctrl_q.sel;
      end
      ADDR_PERIOD: data_o = period_q;
      ADDR_THRESH: data_o = thresh_q;
      ADDR_STATUS: begin
        data_o[7:0] = 8'(fifo_usage);
        data_o[8]   = ovf_q;
        data_o[9]   = irq_q;
      end
      ADDR_DATA: data_o = empty_c ? '0 : fifo_head;
      default:   data_o = '0;
    endcase
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_perf_sampler.sv
// Randomized self-checking bench for perf_sampler against a queue-based behavioural model.
module tb_perf_sampler;
  import perf_sampler_pkg::*;

  localparam int unsigned NC    = 24;
  localparam int unsigned DEPTH = 8;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    debug_mode_i = 1'b0;
  logic [NC-1:0][XLEN-1:0] perf_counter_i;
  logic [2:0]              addr_i = 3'd0;
  logic                    we_i = 1'b0;
  logic                    re_i = 1'b0;
  logic [XLEN-1:0]         data_i = '0;
  logic [XLEN-1:0]         data_o;
  logic                    irq_o;

  perf_sampler #(.NrCounters(NC), .FifoDepth(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .debug_mode_i   (debug_mode_i),
    .perf_counter_i (perf_counter_i),
    .addr_i         (addr_i),
    .we_i           (we_i),
    .re_i           (re_i),
    .data_i         (data_i),
    .data_o         (data_o),
    .irq_o          (irq_o)
  );

  always #5 clk_i = ~clk_i;

  logic [XLEN-1:0] ctr [NC];
  logic [XLEN-1:0] inc [NC];
  always_comb for (int i = 0; i < NC; i++) perf_counter_i[i] = ctr[i];

  int errors = 0;
  int checks = 0;
  longint cyc = 0;
  logic [XLEN-1:0] obs_status = '0;

  // Behavioural model: sampling described by the absolute cycle of the next sample
  bit              m_arming, m_run, m_en, m_ovf, m_irq;
  logic [4:0]      m_sel;
  logic [XLEN-1:0] m_period, m_thresh, m_base;
  longint          m_next;
  logic [XLEN-1:0] m_q [$];

  function automatic logic [XLEN-1:0] mcnt(input logic [4:0] s);
    return (int'(s) < NC) ? ctr[s] : '0;
  endfunction

  function automatic logic [XLEN-1:0] exp_reg(input logic [2:0] a);
    logic [XLEN-1:0] r;
    r = '0;
    case (a)
      3'd0: begin r[0] = m_en; r[8:4] = m_sel; end
      3'd1: r = m_period;
      3'd2: r = m_thresh;
      3'd3: begin r[7:0] = 8'(m_q.size()); r[8] = m_ovf; r[9] = m_irq; end
      3'd4: r = (m_q.size() > 0) ? m_q[0] : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_arming = 0; m_run = 0; m_en = 0; m_ovf = 0; m_irq = 0;
    m_sel = '0; m_period = '0; m_thresh = '0; m_base = '0; m_next = 0;
    m_q.delete();
  endtask

  task automatic model_edge();
    bit wc, wp, ws, pop, samp;
    logic [XLEN-1:0] cv, d;
    wc = we_i && addr_i == 3'd0;
    wp = we_i && addr_i == 3'd1;
    ws = we_i && addr_i == 3'd3;
    pop = re_i && addr_i == 3'd4 && m_q.size() > 0;
    cv = mcnt(m_sel);
    samp = 0; d = '0;
    if (m_arming) begin
      m_base = cv;
      m_next = cyc + longint'(wp ? data_i : m_period);
      m_arming = 0; m_run = 1;
    end else if (m_run && !wc) begin
      if (wp) m_next = cyc + longint'(data_i);
      else if (debug_mode_i || m_period == 0) m_next++;
      else if (cyc == m_next) begin
        samp = 1; d = cv - m_base; m_base = cv; m_next = cyc + longint'(m_period);
      end
    end
    if (pop) void'(m_q.pop_front());
    if (ws) begin
      if (data_i[8]) m_ovf = 0;
      if (data_i[9]) m_irq = 0;
    end
    if (samp) begin
      if (m_thresh != 0 && d >= m_thresh) m_irq = 1;
      if (m_q.size() < DEPTH) m_q.push_back(d); else m_ovf = 1;
    end
    if (wc) begin
      m_sel = data_i[8:4]; m_en = data_i[0];
      m_arming = data_i[0]; m_run = 0;
    end
    if (wp) m_period = data_i;
    if (we_i && addr_i == 3'd2) m_thresh = data_i;
  endtask

  // One clock: model update, edge, then compare STATUS, DATA, irq_o and one random register
  task automatic cycle();
    logic [2:0] ra;
    model_edge();
    @(posedge clk_i); #1;
    cyc++;
    we_i = 0; re_i = 0;
    for (int i = 0; i < NC; i++) ctr[i] = ctr[i] + inc[i];
    addr_i = 3'd3; #1;
    obs_status = data_o;
    checks++;
    if (data_o !== exp_reg(3'd3)) begin
      errors++; $display("FAIL status cyc=%0d got=%h exp=%h", cyc, data_o, exp_reg(3'd3));
    end
    checks++;
    if (irq_o !== m_irq) begin
      errors++; $display("FAIL irq_o cyc=%0d got=%b exp=%b", cyc, irq_o, m_irq);
    end
    addr_i = 3'd4; #1;
    checks++;
    if (data_o !== exp_reg(3'd4)) begin
      errors++; $display("FAIL data cyc=%0d got=%h exp=%h", cyc, data_o, exp_reg(3'd4));
    end
    ra = 3'($urandom_range(0, 7));
    addr_i = ra; #1;
    checks++;
    if (data_o !== exp_reg(ra)) begin
      errors++; $display("FAIL reg%0d cyc=%0d got=%h exp=%h", ra, cyc, data_o, exp_reg(ra));
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [XLEN-1:0] d);
    addr_i = a; we_i = 1; data_i = d;
    cycle();
  endtask

  task automatic pop();
    addr_i = 3'd4; re_i = 1;
    cycle();
  endtask

  task automatic drain();
    wr(3'd0, '0);
    for (int n = 0; n < 12 && m_q.size() > 0; n++) pop();
    wr(3'd3, 64'h300);
  endtask

  function automatic logic [XLEN-1:0] ctrl_word(input int sel);
    logic [XLEN-1:0] v;
    v = '0; v[0] = 1'b1; v[8:4] = 5'(sel);
    return v;
  endfunction

  task automatic wait_count(input int target, input string name);
    int n;
    n = 0;
    while (obs_status[7:0] != 8'(target) && n < 40) begin cycle(); n++; end
    checks++;
    if (obs_status[7:0] != 8'(target)) begin
      errors++; $display("FAIL %s timeout count got=%0d exp=%0d", name, obs_status[7:0], target);
    end
  endtask

  task automatic test_reset();
    for (int a = 0; a < 8; a++) begin
      addr_i = 3'(a); #1;
      checks++;
      if (data_o !== '0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", a, data_o); end
    end
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
  endtask

  task automatic test_basic();
    inc[3] = 2;
    wr(3'd1, 64'd4);
    wr(3'd0, ctrl_word(3));
    repeat (14) cycle();
    addr_i = 3'd4; #1;
    checks++;
    if (data_o !== 64'd8) begin errors++; $display("FAIL basic_delta got=%0d exp=8", data_o); end
    addr_i = 3'd3; #1;
    checks++;
    if (data_o[7:0] !== 8'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", data_o[7:0]); end
  endtask

  task automatic test_wrap();
    drain();
    inc[3] = 0; ctr[3] = 64'hFFFF_FFFF_FFFF_FFFE;
    wr(3'd1, 64'd4);
    wr(3'd0, ctrl_word(3));
    cycle();
    ctr[3] = 64'd3;
    wait_count(1, "wrap");
    addr_i = 3'd4; #1;
    checks++;
    if (data_o !== 64'd5) begin errors++; $display("FAIL wrap_delta got=%h exp=5", data_o); end
  endtask

  task automatic test_overflow();
    int n;
    drain();
    inc[3] = 1;
    wr(3'd1, 64'd2);
    wr(3'd0, ctrl_word(3));
    repeat (19) cycle();
    addr_i = 3'd3; #1;
    checks++;
    if (data_o[8:0] !== {1'b1, 8'd8}) begin errors++; $display("FAIL ovf_full got=%h exp=108", data_o[8:0]); end
    n = 0;
    while (cyc != m_next - 1 && n < 10) begin cycle(); n++; end
    wr(3'd3, 64'h100);
    pop();
    addr_i = 3'd3; #1;
    checks++;
    if (data_o[8:0] !== {1'b0, 8'd8}) begin errors++; $display("FAIL ovf_poppush got=%h exp=008", data_o[8:0]); end
  endtask

  task automatic test_threshold();
    drain();
    wr(3'd2, 64'd10);
    inc[3] = 9;
    wr(3'd1, 64'd1);
    wr(3'd0, ctrl_word(3));
    cycle();
    inc[3] = 10;
    cycle();
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL thr_below got=%b exp=0", irq_o); end
    cycle();
    checks++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL thr_equal got=%b exp=1", irq_o); end
    wr(3'd3, 64'h200);
    checks++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL thr_w1c_race got=%b exp=1", irq_o); end
    wr(3'd2, 64'd0);
    wr(3'd3, 64'h200);
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL thr_disabled got=%b exp=0", irq_o); end
  endtask

  task automatic test_debug_reselect();
    longint t1, t2, a;
    drain();
    inc[3] = 1; inc[5] = 7;
    wr(3'd1, 64'd6);
    wr(3'd0, ctrl_word(3));
    wait_count(1, "dbg_first");
    t1 = cyc - 1;
    debug_mode_i = 1;
    repeat (5) cycle();
    debug_mode_i = 0;
    wait_count(2, "dbg_second");
    t2 = cyc - 1;
    checks++;
    if (t2 - t1 != 11) begin errors++; $display("FAIL dbg_interval got=%0d exp=11", t2 - t1); end
    drain();
    wr(3'd0, ctrl_word(3));
    repeat (3) cycle();
    a = cyc;
    wr(3'd0, ctrl_word(5));
    wait_count(1, "resel");
    checks++;
    if (cyc != a + 8) begin errors++; $display("FAIL resel_latency got=%0d exp=%0d", cyc - a, 8); end
    addr_i = 3'd4; #1;
    checks++;
    if (data_o !== 64'd42) begin errors++; $display("FAIL resel_delta got=%0d exp=42", data_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NC; i++) inc[i] = XLEN'($urandom_range(0, 5));
      debug_mode_i = ($urandom_range(0, 9) == 0);
      addr_i = 3'($urandom_range(0, 7));
      re_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        we_i = 1;
        case (addr_i)
          3'd0: data_i = ctrl_word($urandom_range(0, 31)) & {{(XLEN-1){1'b1}}, ($urandom_range(0, 4) != 0)};
          3'd1: data_i = XLEN'($urandom_range(0, 6));
          3'd2: data_i = XLEN'($urandom_range(0, 25));
          default: data_i = {$urandom, $urandom};
        endcase
      end
      cycle();
    end
    debug_mode_i = 0;
  endtask

  task automatic test_reset_mid();
    drain();
    inc[3] = 3;
    wr(3'd2, 64'd1);
    wr(3'd1, 64'd3);
    wr(3'd0, ctrl_word(3));
    wait_count(3, "rst_fill");
    #1 rst_ni = 0;
    #1;
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", irq_o); end
    addr_i = 3'd3; #1;
    checks++;
    if (data_o !== '0) begin errors++; $display("FAIL rst_status got=%h exp=0", data_o); end
    addr_i = 3'd4; #1;
    checks++;
    if (data_o !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", data_o); end
    @(posedge clk_i); #3;
    rst_ni = 1;
    model_reset();
    wr(3'd1, 64'd2);
    repeat (6) cycle();
    addr_i = 3'd3; #1;
    checks++;
    if (data_o[7:0] !== 8'd0) begin errors++; $display("FAIL rst_idle_count got=%0d exp=0", data_o[7:0]); end
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      ctr[i] = {$urandom, $urandom};
      inc[i] = XLEN'($urandom_range(0, 4));
    end
    model_reset();
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1;
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_threshold();
    test_debug_reselect();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
